// File: rtl/lcd_capture_if.sv
// lcd_capture_if: RGB888 video input bus and SDRAM write-FIFO push port.
// master = video source / FIFO side, slave = lcd_capture.
interface lcd_capture_if;
  logic        vid_pix_en;
  logic        vid_vs;
  logic        vid_hs;
  logic        vid_de;
  logic [23:0] vid_rgb;
  logic        wr_en;
  logic [63:0] wr_data;

  modport master (
    output vid_pix_en, vid_vs, vid_hs, vid_de, vid_rgb,
    input  wr_en, wr_data
  );

  modport slave (
    input  vid_pix_en, vid_vs, vid_hs, vid_de, vid_rgb,
    output wr_en, wr_data
  );
endinterface

// File: rtl/lcd_capture.sv
// lcd_capture: RGB888 -> RGB565, 4 pixels per 64-bit word, frame-aligned pushes.
// Optional LCD_CAP_TESTPAT_EN: pixel data replaced by in-frame pixel index.
module lcd_capture #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int FRAME_WORDS = H_ACTIVE * V_ACTIVE / 4,
  parameter int WCNT_W      = 24
) (
  input  logic         clk_50m,
  input  logic         rst,
  input  logic         capture_en,
  input  logic         sdram_init_done,
  lcd_capture_if.slave vif,
  output logic         frame_done,
  output logic         frame_err,
  output logic [7:0]   frame_cnt
);

  localparam logic [WCNT_W-1:0] LAST = WCNT_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, PAD} state_t;

  state_t            state, state_n;
  logic              pe_q, vs_q, de_q, vs_last;
  logic              vs_rise, pix_ok;
  logic [15:0]       pix;
  logic [WCNT_W-1:0] cnt, cnt_n;
  logic [1:0]        slot, slot_n;
  logic [47:0]       pack, pack_n;
  logic              ovr, ovr_n;
  logic              push, done, err_set;
  logic [63:0]       word;
  logic              push_q, done_q, done_d;
  logic [63:0]       word_q;
  logic              unused_hs;

  assign unused_hs = vif.vid_hs;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      pe_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      vs_last <= 1'b0;
    end else begin
      pe_q <= vif.vid_pix_en;
      vs_q <= vif.vid_vs;
      de_q <= vif.vid_de;
      if (pe_q) vs_last <= vs_q;
    end
  end

  assign vs_rise = pe_q & vs_q & ~vs_last;
  assign pix_ok  = pe_q & de_q;

`ifdef LCD_CAP_TESTPAT_EN
  logic [15:0] idx;
  logic        unused_rgb;

  assign unused_rgb = ^vif.vid_rgb;
  assign pix        = idx;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst)
      idx <= '0;
    else if (state_n == CAPTURE && (state != CAPTURE || done))
      idx <= '0;
    else if (state == CAPTURE && pix_ok)
      idx <= idx + 16'd1;
  end
`else
  logic [15:0] pix_q;
  logic        unused_rgb;

  assign unused_rgb = ^{vif.vid_rgb[18:16], vif.vid_rgb[9:8], vif.vid_rgb[2:0]};
  assign pix        = pix_q;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst)
      pix_q <= '0;
    else
      pix_q <= {vif.vid_rgb[23:19], vif.vid_rgb[15:10], vif.vid_rgb[7:3]};
  end
`endif

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      slot  <= '0;
      pack  <= '0;
      ovr   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      slot  <= slot_n;
      pack  <= pack_n;
      ovr   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    slot_n  = slot;
    pack_n  = pack;
    ovr_n   = ovr;
    push    = 1'b0;
    done    = 1'b0;
    err_set = 1'b0;
    word    = '0;
    unique case (state)
      IDLE: begin
        ovr_n = 1'b0;
        if (capture_en && sdram_init_done) state_n = WAIT_VS;
      end
      WAIT_VS: begin
        if (!capture_en) begin
          state_n = IDLE;
        end else if (vs_rise) begin
          state_n = CAPTURE;
          cnt_n   = '0;
          slot_n  = '0;
          ovr_n   = 1'b0;
        end else if (pix_ok && ovr) begin
          err_set = 1'b1;
        end
      end
      CAPTURE: begin
        if (pix_ok) begin
          slot_n = slot + 2'd1;
          pack_n = {pack[31:0], pix};
          if (slot == 2'd3) begin
            push  = 1'b1;
            word  = {pack, pix};
            cnt_n = cnt + WCNT_W'(1);
          end
        end
        // a VS edge landing on the last word starts the next frame at once
        if (push && cnt == LAST) begin
          done   = 1'b1;
          cnt_n  = '0;
          slot_n = '0;
          if (!capture_en) begin
            state_n = IDLE;
          end else if (vs_rise) begin
            state_n = CAPTURE;
          end else begin
            state_n = WAIT_VS;
            ovr_n   = 1'b1;
          end
        end else if (vs_rise) begin
          err_set = 1'b1;
          slot_n  = '0;
          state_n = PAD;
        end
      end
      PAD: begin
        push  = 1'b1;
        cnt_n = cnt + WCNT_W'(1);
        if (cnt == LAST) begin
          done    = 1'b1;
          cnt_n   = '0;
          state_n = capture_en ? WAIT_VS : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      push_q      <= 1'b0;
      word_q      <= '0;
      done_q      <= 1'b0;
      done_d      <= 1'b0;
      vif.wr_en   <= 1'b0;
      vif.wr_data <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      push_q      <= push;
      word_q      <= word;
      done_q      <= done;
      done_d      <= done_q;
      vif.wr_en   <= push_q;
      vif.wr_data <= word_q;
      frame_done  <= done_d;
      frame_err   <= frame_err | err_set;
      if (done_d) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture: directed frames on a reduced 16x6 geometry.
module tb_lcd_capture;
  localparam int H  = 16;
  localparam int V  = 6;
  localparam int FW = H * V / 4;
  localparam logic [23:0] WHITE = 24'hF8FCF8;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       capture_en = 1'b0;
  logic       sdram_init_done = 1'b0;
  logic       frame_done, frame_err;
  logic [7:0] frame_cnt;

  lcd_capture_if vif ();

  lcd_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_50m(clk_50m),
    .rst(rst),
    .capture_en(capture_en),
    .sdram_init_done(sdram_init_done),
    .vif(vif),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #10 clk_50m = ~clk_50m;

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  logic [63:0] wq[$];
  int          wc[$];
  int          ndone = 0;

  always @(negedge clk_50m) begin
    if (vif.wr_en) begin
      wq.push_back(vif.wr_data);
      wc.push_back(cyc);
    end
    if (frame_done) ndone++;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int t_drv, t4;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] x565(input logic [15:0] p);
    return {p[15:11], 3'b0, p[10:5], 2'b0, p[4:0], 3'b0};
  endfunction

  function automatic logic [63:0] exp_word(input int i, input bit first);
`ifdef LCD_CAP_TESTPAT_EN
    logic [15:0] b;
    b = 16'(4 * i);
    return {b, b + 16'd1, b + 16'd2, b + 16'd3};
`else
    if (first && i == 0) return 64'h1111_2222_3333_4444;
    return '1;
`endif
  endfunction

  task automatic px(input logic vs, input logic de, input logic [23:0] rgb);
    @(posedge clk_50m); #1;
    vif.vid_pix_en = 1'b1;
    vif.vid_vs     = vs;
    vif.vid_de     = de;
    vif.vid_hs     = ~de;
    vif.vid_rgb    = rgb;
    t_drv          = cyc;
    @(posedge clk_50m); #1;
    vif.vid_pix_en = 1'b0;
  endtask

  task automatic vs_pulse();
    px(1'b1, 1'b0, 24'h0);
    px(1'b1, 1'b0, 24'h0);
    px(1'b0, 1'b0, 24'h0);
    px(1'b0, 1'b0, 24'h0);
  endtask

  task automatic line(input bit first);
    logic [15:0] pat [4];
    pat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < H; i++) begin
      if (first && i < 4) px(1'b0, 1'b1, x565(pat[i]));
      else px(1'b0, 1'b1, WHITE);
      if (first && i == 3) t4 = t_drv;
    end
    px(1'b0, 1'b0, 24'h0);
    px(1'b0, 1'b0, 24'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  initial begin
    int b, d, bad;
    vif.vid_pix_en = 1'b0;
    vif.vid_vs     = 1'b0;
    vif.vid_hs     = 1'b0;
    vif.vid_de     = 1'b0;
    vif.vid_rgb    = '0;

    // reset and idle without SDRAM ready
    idle(3);
    rst = 1'b0;
    capture_en = 1'b1;
    @(negedge clk_50m);
    chk("rst_wr_en", 64'(vif.wr_en), 64'd0);
    chk("rst_wr_data", vif.wr_data, 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    b = wq.size();
    vs_pulse();
    line(1'b0);
    line(1'b0);
    vs_pulse();
    idle(1000);
    chk("idle_no_wr", 64'(wq.size() - b), 64'd0);

    // full frame
    sdram_init_done = 1'b1;
    idle(2);
    b = wq.size();
    d = ndone;
    vs_pulse();
    line(1'b1);
    for (int l = 1; l < V; l++) line(1'b0);
    idle(10);
    chk("full_words", 64'(wq.size() - b), 64'(FW));
    chk("full_first_word", wq[b], exp_word(0, 1'b1));
    chk("full_latency", 64'(wc[b] - t4), 64'd2 + 64'd1);
    bad = 0;
    for (int i = 0; i < FW; i++)
      if (wq[b + i] !== exp_word(i, 1'b1)) bad++;
    chk("full_data", 64'(bad), 64'd0);
    chk("full_done", 64'(ndone - d), 64'd1);
    chk("full_cnt", 64'(frame_cnt), 64'd1);
    chk("full_err", 64'(frame_err), 64'd0);

    // short frame: VS after 2 lines, then padding
    b = wq.size();
    d = ndone;
    vs_pulse();
    line(1'b0);
    line(1'b0);
    vs_pulse();
    line(1'b0);
    line(1'b0);
    vs_pulse();
    for (int l = 0; l < V; l++) line(1'b0);
    idle(10);
    chk("short_words", 64'(wq.size() - b), 64'(2 * FW));
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (wq[b + i] !== exp_word(i, 1'b0)) bad++;
    chk("short_data", 64'(bad), 64'd0);
    bad = 0;
    for (int j = 0; j < FW - 8; j++)
      if (wq[b + 8 + j] !== 64'd0 || wc[b + 8 + j] != wc[b + 8] + j) bad++;
    chk("short_pad", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < FW; i++)
      if (wq[b + FW + i] !== exp_word(i, 1'b0)) bad++;
    chk("short_next", 64'(bad), 64'd0);
    chk("short_done", 64'(ndone - d), 64'd2);
    chk("short_cnt", 64'(frame_cnt), 64'd3);
    chk("short_err", 64'(frame_err), 64'd1);

    // reset mid-line after 2 pixels
    b = wq.size();
    vs_pulse();
    px(1'b0, 1'b1, WHITE);
    px(1'b0, 1'b1, WHITE);
    rst = 1'b1;
    @(negedge clk_50m);
    chk("midrst_wr_en", 64'(vif.wr_en), 64'd0);
    chk("midrst_err", 64'(frame_err), 64'd0);
    chk("midrst_cnt", 64'(frame_cnt), 64'd0);
    idle(3);
    rst = 1'b0;
    for (int i = 2; i < H; i++) px(1'b0, 1'b1, WHITE);
    px(1'b0, 1'b0, 24'h0);
    line(1'b0);
    line(1'b0);
    idle(10);
    chk("midrst_no_wr", 64'(wq.size() - b), 64'd0);
    chk("midrst_err2", 64'(frame_err), 64'd0);

    // long frame: one extra line before VS
    b = wq.size();
    d = ndone;
    vs_pulse();
    for (int l = 0; l <= V; l++) line(1'b0);
    idle(10);
    chk("long_words", 64'(wq.size() - b), 64'(FW));
    bad = 0;
    for (int i = 0; i < FW; i++)
      if (wq[b + i] !== exp_word(i, 1'b0)) bad++;
    chk("long_data", 64'(bad), 64'd0);
    chk("long_done", 64'(ndone - d), 64'd1);
    chk("long_cnt", 64'(frame_cnt), 64'd1);
    chk("long_err", 64'(frame_err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
